// File: rtl/mem_access_controller_if.sv
// Pipeline-side request/response signals and external memory bus of mem_access_controller.
interface mem_access_controller_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_read;
    logic              d_write;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_sel;
    logic              bus_read;
    logic              bus_write;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              freeze;
    logic              bus_err;

    modport master (
        input  i_req, i_addr, d_read, d_write, d_byte, d_addr, d_wdata, bus_rdata, bus_ack,
        output bus_addr, bus_wdata, bus_sel, bus_read, bus_write, instr, instr_valid,
               d_rdata, d_valid, freeze, bus_err
    );

    modport slave (
        output i_req, i_addr, d_read, d_write, d_byte, d_addr, d_wdata, bus_rdata, bus_ack,
        input  bus_addr, bus_wdata, bus_sel, bus_read, bus_write, instr, instr_valid,
               d_rdata, d_valid, freeze, bus_err
    );
endinterface

// File: rtl/mem_access_controller.sv
// Shares one external memory bus between instruction fetch and data load/store, freezing
// the pipeline while an access is outstanding; data accesses take priority over fetch.
module mem_access_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                     clk,
    input logic                     nrst,
    mem_access_controller_if.master mac
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StDacc, StIacc, StResp} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              data_q;
    logic              fetch_q;
    logic              write_q;
    logic              byte_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [3:0]        bus_sel_q;
    logic              bus_read_q;
    logic              bus_write_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              instr_valid_q;
    logic              d_valid_q;
    logic              bus_err_q;

    logic [7:0]        ld_byte;
    logic [DATA_W-1:0] ld_data;
    logic              expired;
    logic              in_access;
    logic              d_req;

    always_comb begin
        ld_byte = mac.bus_rdata[{lane_q, 3'b000} +: 8];
        ld_data = byte_q ? {{(DATA_W - 8){ld_byte[7]}}, ld_byte} : mac.bus_rdata;
    end

    assign d_req     = mac.d_read | mac.d_write;
    assign expired   = !mac.bus_ack && (cnt_q == CntLast);
    assign in_access = (state_q == StDacc) || (state_q == StIacc);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            data_q        <= 1'b0;
            fetch_q       <= 1'b0;
            write_q       <= 1'b0;
            byte_q        <= 1'b0;
            lane_q        <= '0;
            i_addr_q      <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_sel_q     <= '0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            instr_q       <= '0;
            d_rdata_q     <= '0;
            instr_valid_q <= 1'b0;
            d_valid_q     <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            d_valid_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q   <= '0;
                    data_q  <= d_req;
                    fetch_q <= mac.i_req;
                    if (mac.i_req) i_addr_q <= {mac.i_addr[ADDR_W-1:2], 2'b00};
                    if (d_req) begin
                        write_q     <= mac.d_write;
                        byte_q      <= mac.d_byte;
                        lane_q      <= mac.d_addr[1:0];
                        bus_addr_q  <= {mac.d_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_q   <= mac.d_byte ? (4'b0001 << mac.d_addr[1:0]) : 4'b1111;
                        bus_wdata_q <= mac.d_byte ? {4{mac.d_wdata[7:0]}} : mac.d_wdata;
                        bus_write_q <= mac.d_write;
                        bus_read_q  <= !mac.d_write;
                        state_q     <= StDacc;
                    end else if (mac.i_req) begin
                        bus_addr_q <= {mac.i_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_q  <= 4'b1111;
                        bus_read_q <= 1'b1;
                        state_q    <= StIacc;
                    end
                end
                StDacc: begin
                    if (mac.bus_ack || expired) begin
                        // A timed-out load returns zero so the pipeline still retires it.
                        if (!write_q) d_rdata_q <= mac.bus_ack ? ld_data : '0;
                        if (!mac.bus_ack) bus_err_q <= 1'b1;
                        cnt_q       <= '0;
                        bus_write_q <= 1'b0;
                        if (fetch_q) begin
                            bus_addr_q <= i_addr_q;
                            bus_sel_q  <= 4'b1111;
                            bus_read_q <= 1'b1;
                            state_q    <= StIacc;
                        end else begin
                            bus_read_q <= 1'b0;
                            d_valid_q  <= 1'b1;
                            state_q    <= StResp;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIacc: begin
                    if (mac.bus_ack || expired) begin
                        instr_q <= mac.bus_ack ? mac.bus_rdata : '0;
                        if (!mac.bus_ack) bus_err_q <= 1'b1;
                        cnt_q         <= '0;
                        bus_read_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        d_valid_q     <= data_q;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gating with nrst keeps freeze low throughout reset even if requests are held.
    assign mac.freeze      = (state_q == StIdle) ? (nrst & (d_req | mac.i_req)) : in_access;
    assign mac.bus_addr    = bus_addr_q;
    assign mac.bus_wdata   = bus_wdata_q;
    assign mac.bus_sel     = bus_sel_q;
    assign mac.bus_read    = bus_read_q;
    assign mac.bus_write   = bus_write_q;
    assign mac.instr       = instr_q;
    assign mac.instr_valid = instr_valid_q;
    assign mac.d_rdata     = d_rdata_q;
    assign mac.d_valid     = d_valid_q;
    assign mac.bus_err     = bus_err_q;
endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed scenarios plus randomized transactions scored
// against a transaction-level model of the controller.
module tb_mem_access_controller;
    localparam int Timeout = 4;
    localparam int MaxCyc  = 40;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        byt;
        logic        ireq;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] iaddr;
        logic [31:0] drdata;
        logic [31:0] irdata;
        logic [7:0]  ddly;
        logic [7:0]  idly;
    } txn_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    mem_access_controller_if #(.ADDR_W(32), .DATA_W(32)) mac ();

    mem_access_controller #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(Timeout)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .mac (mac)
    );

    int n_vec = 0;
    int n_err = 0;
    txn_t cur;

    // Observed per transaction.
    int          o_nacc, o_frz, o_dv, o_iv, o_lat;
    logic [31:0] o_addr [2];
    logic [3:0]  o_sel  [2];
    logic [31:0] o_wdata[2];
    logic        o_rd   [2];
    logic        o_wr   [2];
    int          o_str  [2];

    // Expected per transaction, plus architectural model state.
    int          e_nacc, e_frz, e_dv, e_iv;
    logic [31:0] e_addr [2];
    logic [3:0]  e_sel  [2];
    logic [31:0] e_wdata[2];
    logic        e_rd   [2];
    logic        e_wr   [2];
    int          e_str  [2];
    logic [31:0] m_instr, m_drd;
    logic        m_err;

    // Memory side: acks access k on its dly[k]-th cycle, or never if dly >= Timeout.
    task automatic run_txn();
        int          k, acc_cyc;
        int          dly [2];
        logic [31:0] rdat[2];
        logic        done;
        k = 0; acc_cyc = 0; done = 1'b0;
        if (cur.rd || cur.wr) begin
            dly[0] = int'(cur.ddly); rdat[0] = cur.drdata;
            dly[1] = int'(cur.idly); rdat[1] = cur.irdata;
        end else begin
            dly[0] = int'(cur.idly); rdat[0] = cur.irdata;
            dly[1] = 0;              rdat[1] = '0;
        end
        o_nacc = 0; o_frz = 0; o_dv = 0; o_iv = 0; o_lat = -1;
        for (int i = 0; i < 2; i++) begin
            o_addr[i] = '0; o_sel[i] = '0; o_wdata[i] = '0; o_rd[i] = 1'b0; o_wr[i] = 1'b0;
            o_str[i] = 0;
        end
        @(negedge clk);
        mac.i_req = cur.ireq;  mac.i_addr = cur.iaddr;
        mac.d_read = cur.rd;   mac.d_write = cur.wr;   mac.d_byte = cur.byt;
        mac.d_addr = cur.daddr; mac.d_wdata = cur.dwdata;
        #1;
        if (mac.freeze) o_frz++;
        for (int c = 1; c < MaxCyc && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mac.i_req = 1'b0; mac.d_read = 1'b0; mac.d_write = 1'b0;
            end
            mac.bus_ack   = 1'b0;
            mac.bus_rdata = $urandom();
            if (mac.freeze) o_frz++;
            if (mac.d_valid) o_dv++;
            if (mac.instr_valid) o_iv++;
            if (mac.d_valid || mac.instr_valid) begin
                done = 1'b1; o_lat = c;
            end
            if (mac.bus_read || mac.bus_write) begin
                if (acc_cyc == 0) begin
                    if (k < 2) begin
                        o_addr[k] = mac.bus_addr; o_sel[k] = mac.bus_sel;
                        o_wdata[k] = mac.bus_wdata; o_rd[k] = mac.bus_read;
                        o_wr[k] = mac.bus_write;
                    end
                    o_nacc++;
                end
                if (k < 2) begin
                    o_str[k]++;
                    if (acc_cyc == dly[k]) begin
                        mac.bus_ack = 1'b1; mac.bus_rdata = rdat[k];
                        k++; acc_cyc = 0;
                    end else begin
                        acc_cyc++;
                        if (acc_cyc == Timeout) begin
                            k++; acc_cyc = 0;
                        end
                    end
                end
            end
        end
        mac.bus_ack = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL txn_done: got no valid pulse, required one within %0d cycles", MaxCyc);
        end
    endtask

    task automatic model_txn();
        logic       is_wr;
        logic [7:0] b;
        is_wr  = cur.wr;
        e_nacc = 0; e_frz = 1;
        e_dv   = (cur.rd || cur.wr) ? 1 : 0;
        e_iv   = cur.ireq ? 1 : 0;
        if (cur.rd || cur.wr) begin
            e_addr[0]  = cur.daddr & ~32'd3;
            e_sel[0]   = cur.byt ? 4'(1 << (cur.daddr % 4)) : 4'hF;
            e_wdata[0] = cur.byt ? 32'(cur.dwdata[7:0]) * 32'h01010101 : cur.dwdata;
            e_rd[0]    = !is_wr;
            e_wr[0]    = is_wr;
            e_str[0]   = (int'(cur.ddly) < Timeout) ? int'(cur.ddly) + 1 : Timeout;
            if (int'(cur.ddly) >= Timeout) m_err = 1'b1;
            if (!is_wr) begin
                if (int'(cur.ddly) >= Timeout) m_drd = '0;
                else if (cur.byt) begin
                    b     = 8'(cur.drdata >> (8 * (cur.daddr % 4)));
                    m_drd = b[7] ? 32'(b) - 32'd256 : 32'(b);
                end else m_drd = cur.drdata;
            end
            e_frz += e_str[0];
            e_nacc = 1;
        end
        if (cur.ireq) begin
            e_addr[e_nacc]  = cur.iaddr & ~32'd3;
            e_sel[e_nacc]   = 4'hF;
            e_wdata[e_nacc] = '0;
            e_rd[e_nacc]    = 1'b1;
            e_wr[e_nacc]    = 1'b0;
            e_str[e_nacc]   = (int'(cur.idly) < Timeout) ? int'(cur.idly) + 1 : Timeout;
            if (int'(cur.idly) >= Timeout) m_err = 1'b1;
            m_instr = (int'(cur.idly) >= Timeout) ? '0 : cur.irdata;
            e_frz += e_str[e_nacc];
            e_nacc++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({mac.bus_read, mac.bus_write, mac.freeze, mac.bus_err, mac.d_valid,
             mac.instr_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 000000", {mac.bus_read, mac.bus_write,
                     mac.freeze, mac.bus_err, mac.d_valid, mac.instr_valid});
        end
        n_vec++;
        if ({mac.bus_addr, mac.bus_wdata, mac.bus_sel, mac.instr, mac.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h wdata %h sel %h instr %h drd %h required 0",
                     mac.bus_addr, mac.bus_wdata, mac.bus_sel, mac.instr, mac.d_rdata);
        end
        nrst = 1'b1;
        m_instr = '0; m_drd = '0; m_err = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mac.freeze !== 1'b0 || mac.bus_read !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got freeze %b read %b required 0 0", mac.freeze,
                     mac.bus_read);
        end
    endtask

    task automatic test_fetch();
        cur = '0; cur.ireq = 1'b1; cur.iaddr = 32'h100; cur.irdata = 32'h00A00093;
        cur.idly = 8'd1; cur.daddr = $urandom(); cur.dwdata = $urandom();
        run_txn(); model_txn();
        n_vec++;
        if (o_addr[0] !== 32'h100 || o_sel[0] !== 4'hF || o_rd[0] !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_bus: got addr %h sel %b rd %b required 00000100 1111 1",
                     o_addr[0], o_sel[0], o_rd[0]);
        end
        n_vec++;
        if (mac.instr !== 32'h00A00093) begin
            n_err++; $display("FAIL fetch_instr: got %h required 00a00093", mac.instr);
        end
        n_vec++;
        if (o_iv !== 1 || o_dv !== 0) begin
            n_err++; $display("FAIL fetch_pulse: got iv %0d dv %0d required 1 0", o_iv, o_dv);
        end
        n_vec++;
        if (o_frz !== 3 || o_lat !== 3) begin
            n_err++;
            $display("FAIL fetch_freeze: got freeze %0d lat %0d required 3 3", o_frz, o_lat);
        end
    endtask

    task automatic test_byte_load();
        cur = '0; cur.rd = 1'b1; cur.byt = 1'b1; cur.daddr = 32'h2003; cur.drdata = 32'h80000000;
        run_txn(); model_txn();
        n_vec++;
        if (o_addr[0] !== 32'h2000 || o_sel[0] !== 4'b1000 || o_rd[0] !== 1'b1) begin
            n_err++;
            $display("FAIL lb3_bus: got addr %h sel %b rd %b required 00002000 1000 1",
                     o_addr[0], o_sel[0], o_rd[0]);
        end
        n_vec++;
        if (mac.d_rdata !== 32'hFFFFFF80 || o_dv !== 1 || o_lat !== 2) begin
            n_err++;
            $display("FAIL lb3_data: got %h dv %0d lat %0d required ffffff80 1 2",
                     mac.d_rdata, o_dv, o_lat);
        end
        cur.daddr = 32'h2002; cur.drdata = 32'h007F0000;
        run_txn(); model_txn();
        n_vec++;
        if (mac.d_rdata !== 32'h0000007F || o_sel[0] !== 4'b0100) begin
            n_err++;
            $display("FAIL lb2_data: got %h sel %b required 0000007f 0100", mac.d_rdata,
                     o_sel[0]);
        end
    endtask

    task automatic test_store();
        cur = '0; cur.wr = 1'b1; cur.byt = 1'b1; cur.daddr = 32'h2001; cur.dwdata = 32'h123456AB;
        run_txn(); model_txn();
        n_vec++;
        if (o_wr[0] !== 1'b1 || o_rd[0] !== 1'b0 || o_sel[0] !== 4'b0010 ||
            o_wdata[0] !== 32'hABABABAB) begin
            n_err++;
            $display("FAIL sb_bus: got wr %b rd %b sel %b wdata %h required 1 0 0010 abababab",
                     o_wr[0], o_rd[0], o_sel[0], o_wdata[0]);
        end
        n_vec++;
        if (mac.d_rdata !== 32'h0000007F || o_dv !== 1) begin
            n_err++;
            $display("FAIL sb_hold: got drd %h dv %0d required 0000007f 1", mac.d_rdata, o_dv);
        end
        cur.byt = 1'b0; cur.daddr = 32'h2006; cur.dwdata = $urandom();
        run_txn(); model_txn();
        n_vec++;
        if (o_addr[0] !== 32'h2004 || o_sel[0] !== 4'hF || o_wdata[0] !== cur.dwdata) begin
            n_err++;
            $display("FAIL sw_bus: got addr %h sel %b wdata %h required 00002004 1111 %h",
                     o_addr[0], o_sel[0], o_wdata[0], cur.dwdata);
        end
    endtask

    task automatic test_data_and_fetch();
        cur = '0; cur.rd = 1'b1; cur.ireq = 1'b1; cur.daddr = 32'h3008; cur.iaddr = 32'h104;
        cur.drdata = $urandom(); cur.irdata = $urandom();
        run_txn(); model_txn();
        n_vec++;
        if (o_nacc !== 2 || o_addr[0] !== 32'h3008 || o_addr[1] !== 32'h104) begin
            n_err++;
            $display("FAIL both_order: got n %0d addr %h,%h required 2 00003008,00000104",
                     o_nacc, o_addr[0], o_addr[1]);
        end
        n_vec++;
        if (o_dv !== 1 || o_iv !== 1 || o_frz !== 3 || o_lat !== 3) begin
            n_err++;
            $display("FAIL both_resp: got dv %0d iv %0d freeze %0d lat %0d required 1 1 3 3",
                     o_dv, o_iv, o_frz, o_lat);
        end
        n_vec++;
        if (mac.d_rdata !== cur.drdata || mac.instr !== cur.irdata) begin
            n_err++;
            $display("FAIL both_data: got drd %h instr %h required %h %h", mac.d_rdata,
                     mac.instr, cur.drdata, cur.irdata);
        end
    endtask

    task automatic test_random();
        int kind, op;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            op   = int'($urandom_range(0, 2));
            cur.ireq   = (kind != 1);
            cur.rd     = (kind != 0) && (op != 1);
            cur.wr     = (kind != 0) && (op != 0);
            cur.byt    = ($urandom_range(0, 1) == 1);
            cur.daddr  = $urandom(); cur.dwdata = $urandom(); cur.iaddr = $urandom();
            cur.drdata = $urandom(); cur.irdata = $urandom();
            cur.ddly   = 8'($urandom_range(0, Timeout - 1));
            cur.idly   = 8'($urandom_range(0, Timeout - 1));
            run_txn(); model_txn();
            n_vec++;
            if (o_nacc !== e_nacc) begin
                n_err++; $display("FAIL rnd%0d nacc: got %0d required %0d", t, o_nacc, e_nacc);
            end
            for (int k = 0; k < e_nacc; k++) begin
                n_vec++;
                if (o_addr[k] !== e_addr[k] || o_sel[k] !== e_sel[k] || o_rd[k] !== e_rd[k] ||
                    o_wr[k] !== e_wr[k] || o_str[k] !== e_str[k]) begin
                    n_err++;
                    $display("FAIL rnd%0d acc%0d: got %h/%b/%b%b/%0d required %h/%b/%b%b/%0d",
                             t, k, o_addr[k], o_sel[k], o_rd[k], o_wr[k], o_str[k],
                             e_addr[k], e_sel[k], e_rd[k], e_wr[k], e_str[k]);
                end
                if (e_wr[k]) begin
                    n_vec++;
                    if (o_wdata[k] !== e_wdata[k]) begin
                        n_err++;
                        $display("FAIL rnd%0d wdata: got %h required %h", t, o_wdata[k],
                                 e_wdata[k]);
                    end
                end
            end
            n_vec++;
            if (o_frz !== e_frz || o_lat !== e_frz || o_dv !== e_dv || o_iv !== e_iv) begin
                n_err++;
                $display("FAIL rnd%0d timing: got frz %0d lat %0d dv %0d iv %0d required %0d %0d %0d %0d",
                         t, o_frz, o_lat, o_dv, o_iv, e_frz, e_frz, e_dv, e_iv);
            end
            n_vec++;
            if (mac.instr !== m_instr || mac.d_rdata !== m_drd || mac.bus_err !== m_err) begin
                n_err++;
                $display("FAIL rnd%0d regs: got %h %h %b required %h %h %b", t, mac.instr,
                         mac.d_rdata, mac.bus_err, m_instr, m_drd, m_err);
            end
        end
    endtask

    task automatic test_ack_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mac.bus_ack = 1'b1; mac.bus_rdata = $urandom();
            @(negedge clk);
            mac.bus_ack = 1'b0;
            n_vec++;
            if (mac.instr !== m_instr || mac.d_rdata !== m_drd || mac.d_valid !== 1'b0 ||
                mac.instr_valid !== 1'b0 || mac.bus_read !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ack: got instr %h drd %h dv %b iv %b rd %b required %h %h 0 0 0",
                         mac.instr, mac.d_rdata, mac.d_valid, mac.instr_valid, mac.bus_read,
                         m_instr, m_drd);
            end
        end
    endtask

    task automatic test_timeout();
        cur = '0; cur.rd = 1'b1; cur.daddr = 32'h4000; cur.ddly = 8'(Timeout);
        run_txn(); model_txn();
        n_vec++;
        if (o_str[0] !== Timeout || o_nacc !== 1) begin
            n_err++;
            $display("FAIL to_strobe: got %0d cycles %0d accesses required %0d 1", o_str[0],
                     o_nacc, Timeout);
        end
        n_vec++;
        if (mac.bus_err !== 1'b1 || o_dv !== 1 || mac.d_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL to_result: got err %b dv %0d drd %h required 1 1 00000000",
                     mac.bus_err, o_dv, mac.d_rdata);
        end
        cur.ireq = 1'b1; cur.iaddr = 32'h200; cur.ddly = 8'd0; cur.drdata = $urandom();
        cur.idly = 8'(Timeout + 2);
        run_txn(); model_txn();
        n_vec++;
        if (mac.instr !== 32'h0 || mac.d_rdata !== m_drd || o_iv !== 1 || o_dv !== 1 ||
            o_str[1] !== Timeout) begin
            n_err++;
            $display("FAIL to_fetch: got instr %h drd %h iv %0d dv %0d str %0d required 0 %h 1 1 %0d",
                     mac.instr, mac.d_rdata, o_iv, o_dv, o_str[1], m_drd, Timeout);
        end
        cur = '0; cur.ireq = 1'b1; cur.iaddr = 32'h208; cur.irdata = $urandom();
        run_txn(); model_txn();
        n_vec++;
        if (mac.bus_err !== 1'b1 || mac.instr !== cur.irdata) begin
            n_err++;
            $display("FAIL to_sticky: got err %b instr %h required 1 %h", mac.bus_err,
                     mac.instr, cur.irdata);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mac.d_write = 1'b1; mac.d_byte = 1'b0; mac.d_addr = 32'h5004; mac.d_wdata = $urandom();
        @(negedge clk);
        mac.d_write = 1'b0;
        n_vec++;
        if (mac.bus_write !== 1'b1 || mac.freeze !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre: got write %b freeze %b required 1 1", mac.bus_write,
                     mac.freeze);
        end
        #2;
        mac.d_write = 1'b1;
        nrst = 1'b0;
        #1;
        n_vec++;
        if ({mac.bus_write, mac.bus_read, mac.freeze, mac.bus_err} !== 4'b0) begin
            n_err++;
            $display("FAIL ar_flags: got write %b read %b freeze %b err %b required 0 0 0 0",
                     mac.bus_write, mac.bus_read, mac.freeze, mac.bus_err);
        end
        n_vec++;
        if ({mac.bus_addr, mac.bus_wdata, mac.bus_sel, mac.instr, mac.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL ar_data: got addr %h wdata %h sel %b instr %h drd %h required 0",
                     mac.bus_addr, mac.bus_wdata, mac.bus_sel, mac.instr, mac.d_rdata);
        end
        @(negedge clk);
        mac.d_write = 1'b0;
        nrst = 1'b1;
        m_instr = '0; m_drd = '0; m_err = 1'b0;
        cur = '0; cur.ireq = 1'b1; cur.iaddr = 32'h300; cur.irdata = $urandom();
        run_txn(); model_txn();
        n_vec++;
        if (mac.instr !== cur.irdata || o_iv !== 1 || o_frz !== 2 || mac.bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL ar_after: got instr %h iv %0d freeze %0d err %b required %h 1 2 0",
                     mac.instr, o_iv, o_frz, mac.bus_err, cur.irdata);
        end
    endtask

    initial begin
        nrst = 1'b0;
        mac.i_req = 1'b0; mac.i_addr = '0; mac.d_read = 1'b0; mac.d_write = 1'b0;
        mac.d_byte = 1'b0; mac.d_addr = '0; mac.d_wdata = '0;
        mac.bus_rdata = '0; mac.bus_ack = 1'b0;
        m_instr = '0; m_drd = '0; m_err = 1'b0;
        test_reset();
        test_fetch();
        test_byte_load();
        test_store();
        test_data_and_fetch();
        test_random();
        test_ack_idle();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
